// File: rtl/mem_arbiter_pkg.sv
// Shared arbiter state and requester encodings, also consumed by the cache
// controllers' debug/perf logic.
package arbiter_types;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_SERVE_I,
      ARB_SERVE_D
   } arb_state_t;

   typedef enum logic {
      REQ_I,
      REQ_D
   } arb_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-memory port between the I-cache and
// the D-cache. Every transaction is followed by at least one idle cycle.
module mem_arbiter
   import arbiter_types::*;
#(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic              i_resp,
   output logic [LINE_W-1:0] i_rdata,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_resp,
   output logic [LINE_W-1:0] d_rdata,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic              pmem_resp,
   input  logic [LINE_W-1:0] pmem_rdata
);

   arb_state_t state_q, state_d;
   arb_req_t   last_grant_q, last_grant_d;

   logic i_req;
   logic d_req;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   // Read data fans out unqualified; each side trusts it only with its resp.
   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         last_grant_q <= REQ_I;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = d_address;
      pmem_wdata   = d_wdata;
      i_resp       = 1'b0;
      d_resp       = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            // On a tie the side that was not served last takes the port.
            if (i_req && (!d_req || last_grant_q == REQ_D)) begin
               state_d      = ARB_SERVE_I;
               last_grant_d = REQ_I;
            end else if (d_req) begin
               state_d      = ARB_SERVE_D;
               last_grant_d = REQ_D;
            end
         end

         ARB_SERVE_I: begin
            pmem_read    = i_read;
            pmem_address = i_address;
            i_resp       = pmem_resp;
            if (pmem_resp || !i_req) begin
               state_d = ARB_IDLE;
            end
         end

         ARB_SERVE_D: begin
            // A simultaneous read and write request is treated as a write.
            pmem_read  = d_read & ~d_write;
            pmem_write = d_write;
            d_resp     = pmem_resp;
            if (pmem_resp || !d_req) begin
               state_d = ARB_IDLE;
            end
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small wait-state line memory model.
module tb_mem_arbiter;
   import arbiter_types::*;

   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_read = 1'b0;
   logic [ADDR_W-1:0] i_address = '0;
   logic              i_resp;
   logic [LINE_W-1:0] i_rdata;
   logic              d_read = 1'b0;
   logic              d_write = 1'b0;
   logic [ADDR_W-1:0] d_address = '0;
   logic [LINE_W-1:0] d_wdata = '0;
   logic              d_resp;
   logic [LINE_W-1:0] d_rdata;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic              pmem_resp;
   logic [LINE_W-1:0] pmem_rdata = '0;

   int vectors = 0;
   int miscompares = 0;
   int wait_states = 0;
   int wait_cnt = 0;
   logic strobe;

   mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_rdata(d_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
   );

   always #5 clk = ~clk;

   // Memory answers after wait_states full cycles of a held strobe.
   assign strobe    = pmem_read | pmem_write;
   assign pmem_resp = strobe && (wait_cnt == wait_states);

   always @(posedge clk) begin
      if (strobe && !pmem_resp) wait_cnt <= wait_cnt + 1;
      else                      wait_cnt <= 0;
   end

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("vec %0d %s obs=%h exp=%h", vectors, tag, obs, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      // Reset state
      next_cycle();
      next_cycle();
      chk("rst_state", dut.state_q, ARB_IDLE);
      chk("rst_last_grant", dut.last_grant_q, REQ_I);
      chk("rst_strobes", {pmem_read, pmem_write}, 2'b00);
      chk("rst_resps", {i_resp, d_resp}, 2'b00);
      rst = 1'b0;

      // Lone I read, zero-wait memory
      next_cycle();
      i_read = 1'b1; i_address = 16'h1230;
      pmem_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      settle();
      chk("t1_c0_idle_read", pmem_read, 1'b0);
      next_cycle(); settle();
      chk("t1_c1_read", pmem_read, 1'b1);
      chk("t1_c1_write", pmem_write, 1'b0);
      chk("t1_c1_addr", pmem_address, 16'h1230);
      chk("t1_c1_iresp", i_resp, 1'b1);
      chk("t1_c1_irdata", i_rdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      chk("t1_c1_dresp", d_resp, 1'b0);
      next_cycle();
      i_read = 1'b0;
      settle();
      chk("t1_c2_state", dut.state_q, ARB_IDLE);
      chk("t1_c2_read", pmem_read, 1'b0);

      // Tie right after reset: D first, then I
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      next_cycle();
      i_read = 1'b1; i_address = 16'h0040;
      d_write = 1'b1; d_address = 16'h8000;
      d_wdata = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
      settle();
      next_cycle(); settle();
      chk("t2_c1_write", pmem_write, 1'b1);
      chk("t2_c1_read", pmem_read, 1'b0);
      chk("t2_c1_addr", pmem_address, 16'h8000);
      chk("t2_c1_wdata", pmem_wdata, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
      chk("t2_c1_resps", {i_resp, d_resp}, 2'b01);
      next_cycle();
      d_write = 1'b0;
      settle();
      chk("t2_c2_strobes", {pmem_read, pmem_write}, 2'b00);
      next_cycle(); settle();
      chk("t2_c3_read", pmem_read, 1'b1);
      chk("t2_c3_addr", pmem_address, 16'h0040);
      chk("t2_c3_resps", {i_resp, d_resp}, 2'b10);
      next_cycle();
      i_read = 1'b0;
      settle();
      chk("t2_c4_state", dut.state_q, ARB_IDLE);

      // Both held for six transactions: D, I, D, I, D, I
      i_read = 1'b1; i_address = 16'h1111;
      d_read = 1'b1; d_address = 16'h2222;
      settle();
      for (int k = 0; k < 6; k++) begin
         next_cycle(); settle();
         chk($sformatf("t3_g%0d_read", k), pmem_read, 1'b1);
         chk($sformatf("t3_g%0d_addr", k), pmem_address, (k % 2 == 0) ? 16'h2222 : 16'h1111);
         chk($sformatf("t3_g%0d_resps", k), {i_resp, d_resp}, (k % 2 == 0) ? 2'b01 : 2'b10);
         next_cycle();
         if (k == 5) begin
            i_read = 1'b0;
            d_read = 1'b0;
         end
         settle();
         chk($sformatf("t3_g%0d_idle", k), {pmem_read, pmem_write}, 2'b00);
      end

      // D read with three wait states
      wait_states = 3;
      pmem_rdata = 128'hA5A5_A5A5_0000_FFFF_1234_5678_9ABC_DEF0;
      next_cycle();
      d_read = 1'b1; d_address = 16'h2000;
      settle();
      for (int c = 0; c < 4; c++) begin
         next_cycle(); settle();
         chk($sformatf("t4_c%0d_read", c + 1), pmem_read, 1'b1);
         chk($sformatf("t4_c%0d_addr", c + 1), pmem_address, 16'h2000);
         chk($sformatf("t4_c%0d_dresp", c + 1), d_resp, (c == 3) ? 1'b1 : 1'b0);
      end
      chk("t4_drdata", d_rdata, 128'hA5A5_A5A5_0000_FFFF_1234_5678_9ABC_DEF0);
      next_cycle();
      d_read = 1'b0;
      settle();
      chk("t4_c5_state", dut.state_q, ARB_IDLE);
      chk("t4_c5_dresp", d_resp, 1'b0);

      // Asynchronous reset in the middle of an I read
      wait_states = 5;
      next_cycle();
      i_read = 1'b1; i_address = 16'h3000;
      settle();
      next_cycle(); settle();
      chk("t5_c1_read", pmem_read, 1'b1);
      #2;
      rst = 1'b1;
      i_read = 1'b0;
      #1;
      chk("t5_async_read", pmem_read, 1'b0);
      chk("t5_async_iresp", i_resp, 1'b0);
      next_cycle();
      chk("t5_rst_state", dut.state_q, ARB_IDLE);
      chk("t5_rst_last_grant", dut.last_grant_q, REQ_I);
      rst = 1'b0;
      wait_states = 0;
      next_cycle();
      i_read = 1'b1; i_address = 16'h3000;
      d_read = 1'b1; d_address = 16'h3300;
      settle();
      next_cycle(); settle();
      chk("t5_tie_addr", pmem_address, 16'h3300);
      chk("t5_tie_resps", {i_resp, d_resp}, 2'b01);
      next_cycle();
      d_read = 1'b0;
      settle();
      next_cycle(); settle();
      chk("t5_i_addr", pmem_address, 16'h3000);
      chk("t5_i_resps", {i_resp, d_resp}, 2'b10);
      next_cycle();
      i_read = 1'b0;
      settle();

      // D aborts its write; pending I gets the port afterwards
      wait_states = 5;
      next_cycle();
      d_write = 1'b1; d_address = 16'h4000;
      i_read = 1'b1; i_address = 16'h5000;
      settle();
      next_cycle(); settle();
      chk("t6_c1_write", pmem_write, 1'b1);
      chk("t6_c1_dresp", d_resp, 1'b0);
      next_cycle();
      d_write = 1'b0;
      settle();
      chk("t6_c2_dresp", d_resp, 1'b0);
      chk("t6_c2_write", pmem_write, 1'b0);
      next_cycle();
      wait_states = 0;
      settle();
      chk("t6_c3_state", dut.state_q, ARB_IDLE);
      chk("t6_c3_dresp", d_resp, 1'b0);
      next_cycle(); settle();
      chk("t6_c4_read", pmem_read, 1'b1);
      chk("t6_c4_addr", pmem_address, 16'h5000);
      chk("t6_c4_resps", {i_resp, d_resp}, 2'b10);
      next_cycle();
      i_read = 1'b0;
      settle();
      chk("t6_c5_state", dut.state_q, ARB_IDLE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
